// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staged reset sequencer on the always-on reference clock.
// Asserts every downstream reset together, holds, then releases in index order.
//
// Ports:
//   CLK         reference clock, rising edge
//   RST         asynchronous active-high reset (power-on)
//   SW_RST_REQ  software reset request, sampled on CLK
//   DOM_RST_N   per-domain active-low reset request, bit 0 released first
//   BUSY        high while any DOM_RST_N bit is low
//   DONE        one-cycle pulse on the edge the last domain is released
//   RST_CAUSE   (only with RST_SEQ_CAUSE_EN) 01 = power-on, 10 = software
//
// Build option: define RST_SEQ_CAUSE_EN to add the RST_CAUSE output.

module rst_seq_gen #(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   SW_RST_REQ,
   output logic [NUM_DOMAINS-1:0] DOM_RST_N,
   output logic                   BUSY,
   output logic                   DONE
`ifdef RST_SEQ_CAUSE_EN
   ,
   output logic [1:0]             RST_CAUSE
`endif
);

   localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

   // Release happens on the edge where the counter already shows N-1,
   // so that domain i rises HOLD + i*GAP edges after the start edge.
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic                 ONE_DOM   = (NUM_DOMAINS == 1);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic [IDX_W-1:0]       idx_q;
   logic [IDX_W-1:0]       idx_d;
   logic [NUM_DOMAINS-1:0] dom_q;
   logic [NUM_DOMAINS-1:0] dom_d;
   logic                   busy_q;
   logic                   busy_d;
   logic                   done_q;
   logic                   done_d;

   logic                   hold_fire;
   logic                   gap_fire;
   logic                   rel_fire;
   logic                   last_rel;
   logic [NUM_DOMAINS-1:0] rel_mask;

   assign hold_fire = (state_q == S_HOLD) && (cnt_q == HOLD_LAST);
   assign gap_fire  = (state_q == S_RELEASE) && (cnt_q == GAP_LAST);
   assign rel_fire  = hold_fire || gap_fire;

   // The release that completes the sequence: either the first release
   // of a single-domain build, or the release of the highest index.
   assign last_rel  = (hold_fire && ONE_DOM) ||
                      (gap_fire && (idx_q == IDX_LAST));

   // One-hot select of the domain released on this edge.
   always_comb begin
      rel_mask = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         rel_mask[i] = (idx_q == IDX_W'(i));
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (SW_RST_REQ) begin
         state_d = S_HOLD;
      end else begin
         unique case (state_q)
            S_HOLD: begin
               if (hold_fire) begin
                  state_d = ONE_DOM ? S_RUN : S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (last_rel) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               state_d = S_RUN;
            end
            default: begin
               state_d = S_HOLD;
            end
         endcase
      end
   end

   // ---------------- output / datapath logic ----------------
   // A software request overrides a release falling on the same edge,
   // which also suppresses DONE on the would-be RUN entry edge.
   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      dom_d  = dom_q;
      busy_d = busy_q;
      done_d = 1'b0;
      priority case (1'b1)
         SW_RST_REQ: begin
            cnt_d  = '0;
            idx_d  = '0;
            dom_d  = '0;
            busy_d = 1'b1;
         end
         rel_fire: begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            dom_d = dom_q | rel_mask;
            if (last_rel) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         (state_q != S_RUN): begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         dom_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         dom_q  <= dom_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign DOM_RST_N = dom_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

`ifdef RST_SEQ_CAUSE_EN
   logic [1:0] cause_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cause_q <= 2'b01;
      end else if (SW_RST_REQ) begin
         cause_q <= 2'b10;
      end
   end

   assign RST_CAUSE = cause_q;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: directed vector table, hand sequences and randomized
// requests checked against an edge-count model of the reset sequence.

module tb_rst_seq_gen;

   localparam int N    = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 4;
   localparam int LAST = HOLD + (N - 1) * GAP;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SW_RST_REQ = 1'b0;
   logic [2:0] dom;
   logic       busy;
   logic       done;
`ifdef RST_SEQ_CAUSE_EN
   logic [1:0] cause;
`endif

   int errors = 0;
   int checks = 0;
   int cur_edge = 0;

   // Model: number of edges since the sequence start (saturating).
   int t = 0;

   always #5 CLK = ~CLK;

   rst_seq_gen #(
      .NUM_DOMAINS(N),
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES(GAP),
      .CNT_WIDTH(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .SW_RST_REQ(SW_RST_REQ),
      .DOM_RST_N(dom),
      .BUSY(busy),
      .DONE(done)
`ifdef RST_SEQ_CAUSE_EN
      ,
      .RST_CAUSE(cause)
`endif
   );

   always @(posedge CLK or posedge RST) begin
      if (RST) t <= 0;
      else if (SW_RST_REQ) t <= 0;
      else if (t <= LAST) t <= t + 1;
   end

   function automatic logic [2:0] m_dom(int tt);
      logic [2:0] m;
      for (int i = 0; i < N; i++) m[i] = (tt >= HOLD + i * GAP);
      return m;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (edge %0d)",
                  nm, act, exp, cur_edge);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      cur_edge++;
      @(negedge CLK);
      chk("model dom", 32'(dom), 32'(m_dom(t)));
      chk("model busy", 32'(busy), 32'(t < LAST));
      chk("model done", 32'(done), 32'(t == LAST));
   endtask

   task automatic por();
      @(negedge CLK);
      RST = 1'b1;
      SW_RST_REQ = 1'b0;
      #3;
      chk("async dom", 32'(dom), 32'd0);
      chk("async busy", 32'(busy), 32'd1);
      chk("async done", 32'(done), 32'd0);
      #4;
      RST = 1'b0;
      @(negedge CLK);
      cur_edge = 0;
   endtask

   typedef struct {
      bit         por;
      int         edge_n;
      bit         sw;
      logic [2:0] dom;
      bit         busy;
      bit         done;
   } vec_t;

   vec_t vecs [28];
   int   dcount;

   initial begin
      vecs = '{
         '{1, 1, 0, 3'b000, 1, 0},
         '{0, 15, 0, 3'b000, 1, 0},
         '{0, 16, 0, 3'b001, 1, 0},
         '{0, 19, 0, 3'b001, 1, 0},
         '{0, 20, 0, 3'b011, 1, 0},
         '{0, 23, 0, 3'b011, 1, 0},
         '{0, 24, 0, 3'b111, 0, 1},
         '{0, 25, 0, 3'b111, 0, 0},
         '{0, 40, 1, 3'b000, 1, 0},
         '{0, 55, 0, 3'b000, 1, 0},
         '{0, 56, 0, 3'b001, 1, 0},
         '{0, 60, 0, 3'b011, 1, 0},
         '{0, 64, 0, 3'b111, 0, 1},
         '{0, 65, 0, 3'b111, 0, 0},
         '{1, 20, 0, 3'b011, 1, 0},
         '{0, 21, 1, 3'b000, 1, 0},
         '{0, 36, 0, 3'b000, 1, 0},
         '{0, 37, 0, 3'b001, 1, 0},
         '{0, 41, 0, 3'b011, 1, 0},
         '{0, 44, 0, 3'b011, 1, 0},
         '{0, 45, 0, 3'b111, 0, 1},
         '{0, 46, 0, 3'b111, 0, 0},
         '{1, 16, 1, 3'b000, 1, 0},
         '{0, 31, 0, 3'b000, 1, 0},
         '{0, 32, 0, 3'b001, 1, 0},
         '{0, 39, 0, 3'b011, 1, 0},
         '{0, 40, 1, 3'b000, 1, 0},
         '{0, 41, 0, 3'b000, 1, 0}
      };

      // Vector table
      for (int k = 0; k < 28; k++) begin
         if (vecs[k].por) por();
         while (cur_edge < vecs[k].edge_n - 1) step();
         SW_RST_REQ = vecs[k].sw;
         step();
         SW_RST_REQ = 1'b0;
         chk($sformatf("vec%0d dom", k), 32'(dom), 32'(vecs[k].dom));
         chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vecs[k].busy));
         chk($sformatf("vec%0d done", k), 32'(done), 32'(vecs[k].done));
      end

      // RST pulse mid-sequence right after edge 18
      por();
      while (cur_edge < 17) step();
      @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      chk("mid rst dom", 32'(dom), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd1);
      chk("mid rst done", 32'(done), 32'd0);
      #1 RST = 1'b0;
      @(negedge CLK);
      cur_edge = 0;
      repeat (15) step();
      chk("post rst edge15 dom", 32'(dom), 32'd0);
      step();
      chk("post rst edge16 dom", 32'(dom), 32'd1);

      // SW request held high on edges 30..33
      por();
`ifdef RST_SEQ_CAUSE_EN
      chk("cause por", 32'(cause), 32'd1);
`endif
      while (cur_edge < 29) step();
      SW_RST_REQ = 1'b1;
      repeat (4) step();
      SW_RST_REQ = 1'b0;
      chk("held sw dom", 32'(dom), 32'd0);
      dcount = 0;
      repeat (40) begin
         step();
         if (done) dcount++;
         if (cur_edge == 48) chk("held e48 dom", 32'(dom), 32'd0);
         if (cur_edge == 49) chk("held e49 dom", 32'(dom), 32'd1);
         if (cur_edge == 57) chk("held e57 done", 32'(done), 32'd1);
      end
      chk("held done count", 32'(dcount), 32'd1);
`ifdef RST_SEQ_CAUSE_EN
      chk("cause sw run", 32'(cause), 32'd2);
      por();
      chk("cause new por", 32'(cause), 32'd1);
`endif

      // Randomized requests and async resets against the model
      por();
      repeat (3000) begin
         if ($urandom_range(0, 199) == 0) begin
            #2 RST = 1'b1;
            #2 RST = 1'b0;
         end
         SW_RST_REQ = ($urandom_range(0, 29) == 0);
         step();
      end
      SW_RST_REQ = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
